// File: rtl/llc_arb_pkg.sv
// Shared types for the LLC input arbiter: channel identifiers and the registered output packet.
package llc_arb_pkg;

    localparam int unsigned ARB_PAYLOAD_W = 128;
    localparam int unsigned NUM_CHAN      = 4;

    typedef logic [1:0] chan_id_t;

    localparam chan_id_t CHAN_RST = 2'd0;
    localparam chan_id_t CHAN_RSP = 2'd1;
    localparam chan_id_t CHAN_REQ = 2'd2;
    localparam chan_id_t CHAN_DMA = 2'd3;

    typedef struct packed {
        chan_id_t                 chan;
        logic [ARB_PAYLOAD_W-1:0] data;
    } arb_out_packet_t;

    // Encode a one-hot grant vector into its channel id.
    function automatic chan_id_t onehot_to_chan(input logic [NUM_CHAN-1:0] oh);
        chan_id_t id;
        id = CHAN_RST;
        if (oh[CHAN_RSP]) id = CHAN_RSP;
        if (oh[CHAN_REQ]) id = CHAN_REQ;
        if (oh[CHAN_DMA]) id = CHAN_DMA;
        return id;
    endfunction

endpackage

// File: rtl/llc_arb_prio_sel.sv
// Fixed-priority one-hot grant: rst_tb > rsp > req > dma, with DMA promoted
// above rsp/req (never above rst_tb) when the starvation limit is reached.
module llc_arb_prio_sel
    import llc_arb_pkg::*;
(
    input  logic [NUM_CHAN-1:0] elig_i,
    input  logic                starve_i,
    output logic [NUM_CHAN-1:0] grant_o
);

    always_comb begin
        grant_o = '0;
        if (elig_i[CHAN_RST]) begin
            grant_o[CHAN_RST] = 1'b1;
        end else if (starve_i && elig_i[CHAN_DMA]) begin
            grant_o[CHAN_DMA] = 1'b1;
        end else if (elig_i[CHAN_RSP]) begin
            grant_o[CHAN_RSP] = 1'b1;
        end else if (elig_i[CHAN_REQ]) begin
            grant_o[CHAN_REQ] = 1'b1;
        end else if (elig_i[CHAN_DMA]) begin
            grant_o[CHAN_DMA] = 1'b1;
        end
    end

endmodule

// File: rtl/llc_input_arbiter.sv
// LLC front-end arbiter: merges reset/flush, coherence rsp/req and DMA channels
// into one registered, channel-tagged request stream with full throughput.
module llc_input_arbiter
    import llc_arb_pkg::*;
#(
    parameter int unsigned PAYLOAD_W    = ARB_PAYLOAD_W,
    parameter int unsigned STARVE_LIMIT = 8,
    parameter int unsigned CNT_W        = 4
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 rst_tb_valid,
    output logic                 rst_tb_ready,
    input  logic [PAYLOAD_W-1:0] rst_tb_data,

    input  logic                 rsp_valid,
    output logic                 rsp_ready,
    input  logic [PAYLOAD_W-1:0] rsp_data,

    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [PAYLOAD_W-1:0] req_data,

    input  logic                 dma_valid,
    output logic                 dma_ready,
    input  logic [PAYLOAD_W-1:0] dma_data,

    input  logic                 req_stall,
    input  logic                 rst_done,

    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [1:0]           out_chan,
    output logic [PAYLOAD_W-1:0] out_data,
    output logic                 busy
);

    logic [NUM_CHAN-1:0]  elig;
    logic [NUM_CHAN-1:0]  grant;
    logic [NUM_CHAN-1:0]  xfer;
    logic                 starve;
    logic                 adv;
    logic                 any_xfer;
    logic [PAYLOAD_W-1:0] gnt_data;

    logic                 active_q;
    logic                 busy_q,      busy_d;
    logic [CNT_W-1:0]     cnt_q,       cnt_d;
    logic                 out_valid_q, out_valid_d;
    arb_out_packet_t      out_q,       out_d;

    // During the flush/reset window only responses may drain.
    assign elig = {dma_valid    & ~busy_q,
                   req_valid    & ~req_stall & ~busy_q,
                   rsp_valid,
                   rst_tb_valid & ~busy_q};

    assign starve = (cnt_q == CNT_W'(STARVE_LIMIT));
    assign adv    = ~out_valid_q | out_ready;

    llc_arb_prio_sel u_prio_sel (
        .elig_i   (elig),
        .starve_i (starve),
        .grant_o  (grant)
    );

    // active_q keeps every ready low while reset is asserted.
    assign xfer     = grant & {NUM_CHAN{adv & active_q}};
    assign any_xfer = |xfer;

    assign rst_tb_ready = xfer[CHAN_RST];
    assign rsp_ready    = xfer[CHAN_RSP];
    assign req_ready    = xfer[CHAN_REQ];
    assign dma_ready    = xfer[CHAN_DMA];

    always_comb begin
        gnt_data = dma_data;
        if (grant[CHAN_RST]) begin
            gnt_data = rst_tb_data;
        end else if (grant[CHAN_RSP]) begin
            gnt_data = rsp_data;
        end else if (grant[CHAN_REQ]) begin
            gnt_data = req_data;
        end
    end

    // Next-state for output register, starvation counter and busy window.
    always_comb begin
        out_valid_d = out_valid_q;
        out_d       = out_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;

        if (adv) begin
            out_valid_d = any_xfer;
            if (any_xfer) begin
                out_d.chan = onehot_to_chan(grant);
                out_d.data = ARB_PAYLOAD_W'(gnt_data);
            end
        end

        if (!dma_valid || xfer[CHAN_DMA]) begin
            cnt_d = '0;
        end else if ((xfer[CHAN_RSP] || xfer[CHAN_REQ]) && !starve) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (xfer[CHAN_RST]) begin
            busy_d = 1'b1;
        end else if (rst_done) begin
            busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active_q    <= 1'b0;
            busy_q      <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            active_q    <= 1'b1;
            busy_q      <= busy_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_chan  = out_q.chan;
    assign out_data  = PAYLOAD_W'(out_q.data);
    assign busy      = busy_q;

endmodule

// File: doc/llc_input_arbiter.md
Name: llc_input_arbiter

Overview:
- Upstream front end of the LLC pipeline, directly feeding the decode/READ_SET stage of the LLC core.
- Arbitrates four inbound channels into one registered, tagged request stream: reset/flush testbench, coherence response, coherence request, DMA request.
- Applies a fixed priority with a DMA anti-starvation override, a request-stall mask, and a flush/reset blocking window.
- Adds exactly one register stage and sustains full throughput.

Parameters:
- PAYLOAD_W, 128, payload width per channel; callers zero-pad narrower payloads.
- STARVE_LIMIT, 8, number of consecutive non-DMA grants tolerated while DMA is waiting.
- CNT_W, 4, starvation counter width; must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- rst_tb_valid / rst_tb_ready  in/out  1  reset/flush channel handshake
- rst_tb_data  in  PAYLOAD_W  reset/flush payload; bit0=1 means flush, 0 means reset
- rsp_valid / rsp_ready  in/out  1  coherence response handshake
- rsp_data  in  PAYLOAD_W  response payload
- req_valid / req_ready  in/out  1  coherence request handshake
- req_data  in  PAYLOAD_W  request payload
- dma_valid / dma_ready  in/out  1  DMA request handshake
- dma_data  in  PAYLOAD_W  DMA payload
- req_stall  in  1  core has a request stalled on a set; masks the req channel
- rst_done  in  1  single-cycle pulse from core: reset/flush finished
- out_valid  out  1  registered packet valid toward core
- out_ready  in  1  core accepts packet
- out_chan  out  2  0=rst_tb, 1=rsp, 2=req, 3=dma
- out_data  out  PAYLOAD_W  registered payload
- busy  out  1  reset/flush window open

Behaviour:
- Reset (rst=0, async): out_valid=0, out_chan=0, out_data=0, busy=0, starvation counter=0. All *_ready outputs are 0 during reset.
- Eligibility:
  - rst_tb is eligible when valid and !busy.
  - rsp is eligible whenever valid.
  - req is eligible when valid, !req_stall, and !busy.
  - dma is eligible when valid and !busy.
- Priority: rst_tb > rsp > req > dma.
- Starvation override: if the counter equals STARVE_LIMIT and dma is eligible, dma outranks rsp and req but never rst_tb.
- Grant: at most one grant per cycle, computed combinationally from eligibility.
- Advance condition: adv = !out_valid | out_ready.
  - The granted channel's ready = adv. All other readys = 0.
  - Ready may depend on valid. The core must not make valid depend on ready.
- Transfer on a channel (valid & ready): at the next edge out_valid=1 and out_chan/out_data are loaded. Latency is 1 cycle from input handshake to out_valid.
- If out_ready=1 and no grant: out_valid becomes 0 at the next edge.
- While out_valid=1 and out_ready=0: out_chan and out_data are held stable, and all readys are 0.
- Starvation counter:
  - Increments, saturating at STARVE_LIMIT, on each rsp or req transfer while dma_valid=1.
  - Clears on a dma transfer or whenever dma_valid=0.
  - Otherwise holds.
- busy:
  - Set at the edge following an rst_tb transfer.
  - Cleared at the edge where rst_done=1.
  - If both occur in the same cycle, set wins. rst_done while !busy is ignored.
  - During busy only rsp is eligible, so in-flight responses still drain.
- Simultaneous events: a new grant and an output pop may happen in the same cycle; the register is overwritten, so there is no bubble.
- Mid-operation reset: the pending output packet is dropped and busy clears. Upstream must re-present any packet it was sending.

Decomposition:
- Shared package llc_arb_pkg holds:
  - chan_id_t (2 bits) and the CHAN_RST, CHAN_RSP, CHAN_REQ, CHAN_DMA constants;
  - the arb_out_packet_t struct {chan, data}.
- One sub-module, llc_arb_prio_sel: combinational eligibility-to-one-hot grant with the starvation override input.
- The top level holds the output register, starvation counter and busy flag.

Test Plan:
- Single req_valid with data 0xA5, out_ready=1 -> req_ready=1 in the same cycle; next cycle out_valid=1, out_chan=2, out_data=0xA5.
- rsp, req and dma all valid for one cycle -> rsp granted; then req; then dma. out_chan sequence is 1, 2, 3 with no bubbles while out_ready=1.
- dma_valid held, rsp/req valid continuously, STARVE_LIMIT=8 -> after 8 rsp/req grants the 9th grant is dma (out_chan=3), then the counter reads 0.
- rst_tb transfer then req_valid held -> busy=1 and req_ready=0 for 20 cycles; rsp is still accepted. Pulse rst_done -> req granted 1 cycle later.
- out_ready=0 for 5 cycles with out_valid=1 -> out_data stable, all readys 0. Release -> the next grant loads in the same cycle as the pop.
- Assert rst low mid-transfer with out_valid=1 -> out_valid=0 and busy=0 immediately, and no output before rst releases.
